serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 19 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell built from gates; the serial datapath reuses it every cycle.
module full_adder (
    input  logic Ain,
    input  logic Bin,
    input  logic Cin,
    output logic Sout,
    output logic Cout
);

    logic half_sum;

    // Sum and carry from the two-level XOR / majority structure
    always_comb begin
        half_sum = Ain ^ Bin;
        Sout     = half_sum ^ Cin;
        Cout     = (Ain & Bin) | (Cin & half_sum);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell consumes one operand bit per clock,
// LSB first, and publishes {cout_out, sum_out} after WIDTH shift cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_d;
    logic               done_d;
    logic               busy_d;
    logic               fa_sum;
    logic               fa_carry;

    full_adder u_fa (
        .Ain  (a_q[0]),
        .Bin  (b_q[0]),
        .Cin  (carry_q),
        .Sout (fa_sum),
        .Cout (fa_carry)
    );

    // Next-state and datapath update; everything holds unless the FSM says otherwise
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_out;
        cout_d  = cout_out;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = c_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New sum bit enters at the MSB so the first bit ends up at bit 0
                res_d   = WIDTH'({fa_sum, res_q} >> 1);
                carry_d = fa_carry;
                a_d     = WIDTH'(a_q >> 1);
                b_d     = WIDTH'(b_q >> 1);
                if (cnt_q == CNT_LAST) begin
                    // Counter holds on the terminal edge so it never wraps
                    sum_d   = res_d;
                    cout_d  = fa_carry;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sum_out  <= sum_d;
            cout_out <= cout_d;
            done     <= done_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and an exhaustive WIDTH=4 sweep).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;
    logic       done8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       c4;
    logic [3:0] sum4;
    logic       cout4;
    logic       busy4;
    logic       done4;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .a_in     (a8),
        .b_in     (b8),
        .c_in     (c8),
        .sum_out  (sum8),
        .cout_out (cout8),
        .busy     (busy8),
        .done     (done8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .a_in     (a4),
        .b_in     (b4),
        .c_in     (c4),
        .sum_out  (sum4),
        .cout_out (cout4),
        .busy     (busy4),
        .done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 addition with start pulsed for a single cycle
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         lat;
        bit         seen;
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        prev_sum  = sum8;
        prev_cout = cout8;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; c8 = ~c;
        check_eq({tag, "_busy"}, 64'(busy8), 64'(1));
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (done8) begin
                seen = 1'b1;
            end else if (i == 4) begin
                check_eq({tag, "_hold"}, 64'({cout8, sum8}), 64'({prev_cout, prev_sum}));
            end
        end
        check_eq({tag, "_done_seen"}, 64'(seen), 64'(1));
        check_eq({tag, "_latency"}, 64'(lat), 64'(8));
        check_eq({tag, "_sum"}, 64'(sum8), 64'(exp_sum));
        check_eq({tag, "_cout"}, 64'(cout8), 64'(exp_cout));
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 64'(done8), 64'(0));
        check_eq({tag, "_idle"}, 64'(busy8), 64'(0));
    endtask

    // One WIDTH=4 addition; result checked against the integer sum
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        bit seen;
        int exp;
        exp = int'(a) + int'(b) + int'(c);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = ~a; b4 = ~b;
        seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (done4) seen = 1'b1;
        end
        check_eq("w4_done_seen", 64'(seen), 64'(1));
        check_eq("w4_result", 64'({cout4, sum4}), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  n_acc;
        int  n_done;
        int  last_acc;
        int  n_done_rst;
        bit  prev_busy;

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;

        #12;
        check_eq("rst_sum", 64'(sum8), 64'(0));
        check_eq("rst_cout", 64'(cout8), 64'(0));
        check_eq("rst_busy", 64'(busy8), 64'(0));
        check_eq("rst_done", 64'(done8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

        // Start held high: one acceptance every WIDTH+2 cycles, mid-flight operand changes ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
        prev_busy = busy8;
        n_acc = 0; n_done = 0; last_acc = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (busy8 && !prev_busy) begin
                n_acc++;
                if (last_acc > 0) check_eq("hold_spacing", 64'(i - last_acc), 64'(10));
                last_acc = i;
            end
            if (done8) begin
                n_done++;
                check_eq("hold_sum", 64'(sum8), 64'(8'h02));
                check_eq("hold_cout", 64'(cout8), 64'(0));
                a8 = 8'h01; b8 = 8'h01;
            end else if (busy8) begin
                a8 = 8'hFF; b8 = 8'hFF;
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        check_eq("hold_accepts", 64'(n_acc), 64'(3));
        check_eq("hold_dones", 64'(n_done), 64'(3));

        // Put a non-zero result on the outputs so the asynchronous clear is visible
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "pre_rst");

        // Reset during the 4th SHIFT cycle
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; c8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_sum", 64'(sum8), 64'(0));
        check_eq("async_rst_cout", 64'(cout8), 64'(0));
        check_eq("async_rst_busy", 64'(busy8), 64'(0));
        check_eq("async_rst_done", 64'(done8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_done_rst = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) n_done_rst++;
        end
        check_eq("abandoned_no_done", 64'(n_done_rst), 64'(0));
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_rst");

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(a), 4'(b), 1'(c));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
